// File: rtl/rs232_tx.sv
// UART transmitter: holding register plus shift register, start/data/stop framing.
// Define RS232_TX_PARITY_EN to insert an even-parity bit after the data bits.
module rs232_tx #(
   parameter int CLK_DIV   = 16,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 ctrl_wdata,
   output logic                 ctrl_wready,
   output logic                 txd_out,
   output logic                 tx_busy
);

   localparam int CNT_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef RS232_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     baud_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] hold_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 hold_full;
   logic                 busy_q;
`ifdef RS232_TX_PARITY_EN
   logic                 parity_q;
`endif

   logic baud_last;
   logic stop_last;
   logic accept;
   logic drain;
   logic line_bit;

   assign baud_last = (baud_cnt == CNT_W'(CLK_DIV - 1));
   assign stop_last = baud_last && (bit_cnt == BIT_W'(STOP_BITS - 1));
   assign accept    = ctrl_wdata && !hold_full;
   // The holding register empties either from IDLE or straight out of the last
   // stop bit, which is what keeps queued frames contiguous.
   assign drain     = hold_full && ((state == IDLE) || ((state == STOP) && stop_last));

   always_comb begin
      // NOTE: default first so every path assigns line_bit and no latch is inferred.
      line_bit = 1'b1;
      case (state)
         START:   line_bit = 1'b0;
         DATA:    line_bit = shift_reg[0];
`ifdef RS232_TX_PARITY_EN
         PARITY:  line_bit = parity_q;
`endif
         default: line_bit = 1'b1;
      endcase
   end

   // txd_out and busy_q are registered copies of the state, so the line lags the
   // FSM by one cycle: load at the edge after acceptance, start bit one edge later.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         hold_reg  <= '0;
         shift_reg <= '0;
         hold_full <= 1'b0;
         busy_q    <= 1'b0;
         txd_out   <= 1'b1;
`ifdef RS232_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking throughout; every register here updates from pre-edge values.
         txd_out <= line_bit;
         busy_q  <= (state != IDLE) || hold_full;

         if (accept) begin
            hold_reg  <= data_in;
            hold_full <= 1'b1;
         end else if (drain) begin
            hold_full <= 1'b0;
         end

         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (hold_full) state <= START;
            end
            START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud_cnt  <= '0;
                  shift_reg <= shift_reg >> 1;
                  if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                     bit_cnt <= '0;
`ifdef RS232_TX_PARITY_EN
                     state   <= PARITY;
`else
                     state   <= STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
`ifdef RS232_TX_PARITY_EN
            PARITY: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
`endif
            STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (stop_last) begin
                     bit_cnt <= '0;
                     state   <= hold_full ? START : IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase

         if (drain) begin
            shift_reg <= hold_reg;
`ifdef RS232_TX_PARITY_EN
            parity_q  <= ^hold_reg;
`endif
         end
      end
   end

   assign ctrl_wready = !hold_full;
   assign tx_busy     = busy_q || hold_full;

endmodule
